// File: rtl/branch_update_queue_pkg.sv
// rtl/branch_update_queue_pkg.sv - shared types and defaults for the branch update queue
package branch_update_queue_pkg;

  localparam int DEPTH_WIDTH_DEFAULT    = 4;
  localparam int RECOVER_CYCLES_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic        pred_taken;
    logic [31:0] alt_pc;
  } entry_t;

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } state_t;

endpackage

// File: rtl/branch_entry_fifo.sv
// rtl/branch_entry_fifo.sv - circular buffer of predicted branches with push/pop/clear
module branch_entry_fifo
  import branch_update_queue_pkg::*;
#(
  parameter int DEPTH_WIDTH = DEPTH_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  entry_t               push_entry,
  input  logic                 pop,
  input  logic                 clear,
  output entry_t               head_entry,
  output logic [DEPTH_WIDTH:0] count
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_WIDTH:0]   CNT_ONE = 1;

  entry_t                 mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] head;
  logic [DEPTH_WIDTH-1:0] tail;
  logic [DEPTH_WIDTH-1:0] head_nxt;

  assign head_nxt   = pop ? head + PTR_ONE : head;
  assign head_entry = mem[head];

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  // Clearing collapses tail onto the post-pop head so a popped mispredicted branch is also gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= head_nxt;
      tail  <= head_nxt;
      count <= '0;
    end else begin
      head <= head_nxt;
      if (push) tail <= tail + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_update_queue.sv
// rtl/branch_update_queue.sv - in-order predicted-branch queue driving predictor training
module branch_update_queue
  import branch_update_queue_pkg::*;
#(
  parameter int DEPTH_WIDTH    = DEPTH_WIDTH_DEFAULT,
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEFAULT
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 pushValid,
  input  logic [31:0]          pushAddr,
  input  logic                 pushPredTaken,
  input  logic [31:0]          pushAltPc,
  output logic                 pushReady,
  input  logic                 resolveValid,
  input  logic                 resolveTaken,
  input  logic                 flushIn,
  output logic                 updateValid,
  output logic [31:0]          updateInstr,
  output logic                 taken,
  output logic                 mispredict,
  output logic [31:0]          redirectPc,
  output logic [DEPTH_WIDTH:0] count
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH_CNT    = DEPTH[DEPTH_WIDTH:0];
  localparam logic [3:0]           RECOVER_LOAD = RECOVER_CYCLES[3:0];
  localparam logic [3:0]           RCNT_ONE     = 4'd1;

  state_t     state, state_nxt;
  logic [3:0] rcnt, rcnt_nxt;
  logic       ready_en;
  entry_t     head_entry;
  entry_t     push_entry;
  logic       resolve_fire;
  logic       mis;
  logic       push_fire;

  assign push_entry   = '{addr: pushAddr, pred_taken: pushPredTaken, alt_pc: pushAltPc};
  assign resolve_fire = resolveValid && (count != '0);
  // A flush owns the redirect, so a same-cycle wrong prediction only trains.
  assign mis          = resolve_fire && (resolveTaken != head_entry.pred_taken) && !flushIn;
  assign pushReady    = ready_en && (state == NORMAL) && (count < DEPTH_CNT);
  assign push_fire    = pushValid && pushReady && !flushIn && !mis;

  branch_entry_fifo #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_fifo (
    .clk        (clockIn),
    .rst_n      (resetIn),
    .push       (push_fire),
    .push_entry (push_entry),
    .pop        (resolve_fire),
    .clear      (flushIn || mis),
    .head_entry (head_entry),
    .count      (count)
  );

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state    <= NORMAL;
      rcnt     <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      rcnt     <= rcnt_nxt;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    case (state)
      NORMAL: begin
        if (flushIn || mis) begin
          state_nxt = RECOVER;
          rcnt_nxt  = RECOVER_LOAD;
        end
      end
      RECOVER: begin
        if (flushIn) begin
          rcnt_nxt = RECOVER_LOAD;
        end else begin
          rcnt_nxt = rcnt - RCNT_ONE;
          if (rcnt_nxt == '0) state_nxt = NORMAL;
        end
      end
      default: state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      updateValid <= 1'b0;
      updateInstr <= '0;
      taken       <= 1'b0;
      mispredict  <= 1'b0;
      redirectPc  <= '0;
    end else begin
      updateValid <= resolve_fire;
      mispredict  <= mis;
      if (resolve_fire) begin
        updateInstr <= head_entry.addr;
        taken       <= resolveTaken;
      end
      if (mis) redirectPc <= head_entry.alt_pc;
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// tb/tb_branch_update_queue.sv - scoreboard bench for branch_update_queue
module tb_branch_update_queue;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        pushValid;
  logic [31:0] pushAddr;
  logic        pushPredTaken;
  logic [31:0] pushAltPc;
  logic        pushReady;
  logic        resolveValid;
  logic        resolveTaken;
  logic        flushIn;
  logic        updateValid;
  logic [31:0] updateInstr;
  logic        taken;
  logic        mispredict;
  logic [31:0] redirectPc;
  logic [4:0]  count;

  typedef struct {
    logic [31:0] instr;
    logic        tk;
    logic        mis;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_update_queue dut (
    .clockIn       (clockIn),
    .resetIn       (resetIn),
    .pushValid     (pushValid),
    .pushAddr      (pushAddr),
    .pushPredTaken (pushPredTaken),
    .pushAltPc     (pushAltPc),
    .pushReady     (pushReady),
    .resolveValid  (resolveValid),
    .resolveTaken  (resolveTaken),
    .flushIn       (flushIn),
    .updateValid   (updateValid),
    .updateInstr   (updateInstr),
    .taken         (taken),
    .mispredict    (mispredict),
    .redirectPc    (redirectPc),
    .count         (count)
  );

  always #5 clockIn = ~clockIn;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clockIn);
    #1;
  endtask

  task automatic idle();
    pushValid    = 1'b0;
    resolveValid = 1'b0;
    flushIn      = 1'b0;
  endtask

  task automatic set_push(input logic [31:0] a, input logic pt, input logic [31:0] alt);
    pushValid     = 1'b1;
    pushAddr      = a;
    pushPredTaken = pt;
    pushAltPc     = alt;
  endtask

  task automatic set_resolve(input logic tk, input logic [31:0] instr, input logic mis,
                             input logic [31:0] rpc);
    exp_t e;
    resolveValid = 1'b1;
    resolveTaken = tk;
    e.instr = instr;
    e.tk    = tk;
    e.mis   = mis;
    e.rpc   = rpc;
    sb.push_back(e);
  endtask

  // Monitor: every update strobe must match the oldest expected resolve.
  always @(negedge clockIn) begin
    if (updateValid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_update: got instr %0h expected no update", updateInstr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("update_instr", updateInstr, e.instr);
        chk("update_taken", {31'd0, taken}, {31'd0, e.tk});
        chk("mispredict", {31'd0, mispredict}, {31'd0, e.mis});
        if (e.mis) chk("redirect_pc", redirectPc, e.rpc);
      end
    end else if (mispredict) begin
      n_checks++;
      n_fail++;
      $display("FAIL stray_mispredict: got 1 expected 0 without update");
    end
  end

  initial begin
    resetIn = 1'b0;
    idle();
    pushAddr = '0; pushPredTaken = 1'b0; pushAltPc = '0; resolveTaken = 1'b0;
    tick(); tick();
    chk("reset_pushready", {31'd0, pushReady}, 32'd0);
    chk("reset_count", {27'd0, count}, 32'd0);
    chk("reset_updatevalid", {31'd0, updateValid}, 32'd0);
    chk("reset_mispredict", {31'd0, mispredict}, 32'd0);
    resetIn = 1'b1;
    tick();
    chk("release_pushready", {31'd0, pushReady}, 32'd1);
    chk("release_count", {27'd0, count}, 32'd0);

    // Correct prediction
    set_push(32'h100, 1'b1, 32'h104); tick(); idle();
    chk("t1_count_after_push", {27'd0, count}, 32'd1);
    set_resolve(1'b1, 32'h100, 1'b0, 32'h0); tick(); idle();
    chk("t1_count_after_resolve", {27'd0, count}, 32'd0);
    tick();

    // Mispredict, then 2-cycle recovery
    set_push(32'h200, 1'b0, 32'h280); tick(); idle();
    set_resolve(1'b1, 32'h200, 1'b1, 32'h280); tick(); idle();
    chk("t2_count", {27'd0, count}, 32'd0);
    chk("t2_ready_c1", {31'd0, pushReady}, 32'd0);
    tick();
    chk("t2_ready_c2", {31'd0, pushReady}, 32'd0);
    chk("t2_redirect_hold", redirectPc, 32'h280);
    tick();
    chk("t2_ready_back", {31'd0, pushReady}, 32'd1);

    // Fill to 16, 17th push ignored, then push+resolve around full with pointer wrap
    for (int i = 0; i < 17; i++) begin
      set_push(32'h1000 + 32'(i) * 4, i[0], 32'h2000 + 32'(i) * 4);
      tick();
    end
    idle();
    chk("full_count", {27'd0, count}, 32'd16);
    chk("full_pushready", {31'd0, pushReady}, 32'd0);
    set_resolve(1'b0, 32'h1000, 1'b0, 32'h0); tick(); idle();
    chk("free_count", {27'd0, count}, 32'd15);
    chk("free_pushready", {31'd0, pushReady}, 32'd1);
    set_push(32'h1040, 1'b0, 32'h2040);
    set_resolve(1'b1, 32'h1004, 1'b0, 32'h0); tick(); idle();
    chk("pushpop_count", {27'd0, count}, 32'd15);
    set_push(32'h1044, 1'b1, 32'h2044); tick(); idle();
    chk("refull_count", {27'd0, count}, 32'd16);
    for (int i = 2; i < 18; i++) begin
      set_resolve(i[0], 32'h1000 + 32'(i) * 4, 1'b0, 32'h0);
      tick();
    end
    idle();
    chk("drain_count", {27'd0, count}, 32'd0);
    tick();

    // Flush with 5 entries, same-cycle push and correct resolve
    for (int i = 0; i < 5; i++) begin
      set_push(32'h3000 + 32'(i) * 4, 1'b1, 32'h3100 + 32'(i) * 4);
      tick();
    end
    idle();
    chk("flush_pre_count", {27'd0, count}, 32'd5);
    flushIn = 1'b1;
    set_push(32'h3800, 1'b0, 32'h3900);
    set_resolve(1'b1, 32'h3000, 1'b0, 32'h0);
    tick(); idle();
    chk("flush_count", {27'd0, count}, 32'd0);
    chk("flush_ready_c1", {31'd0, pushReady}, 32'd0);
    tick();
    chk("flush_ready_c2", {31'd0, pushReady}, 32'd0);
    tick();
    chk("flush_ready_back", {31'd0, pushReady}, 32'd1);

    // Flush beats a wrong prediction: training kept, no mispredict
    set_push(32'h4000, 1'b1, 32'h4100); tick(); idle();
    flushIn = 1'b1;
    set_resolve(1'b0, 32'h4000, 1'b0, 32'h0);
    tick(); idle();
    chk("flushmis_count", {27'd0, count}, 32'd0);
    tick(); tick();
    chk("flushmis_ready_back", {31'd0, pushReady}, 32'd1);

    // Resolve on an empty queue
    resolveValid = 1'b1; resolveTaken = 1'b1;
    tick(); idle();
    chk("empty_resolve_count", {27'd0, count}, 32'd0);
    tick();
    chk("empty_resolve_ready", {31'd0, pushReady}, 32'd1);

    // Reset mid-queue
    for (int i = 0; i < 3; i++) begin
      set_push(32'h5000 + 32'(i) * 4, 1'b0, 32'h5100);
      tick();
    end
    idle();
    chk("midreset_pre_count", {27'd0, count}, 32'd3);
    resolveValid = 1'b1; resolveTaken = 1'b1;
    resetIn = 1'b0;
    #1;
    chk("midreset_count", {27'd0, count}, 32'd0);
    chk("midreset_pushready", {31'd0, pushReady}, 32'd0);
    tick(); tick();
    idle();
    resetIn = 1'b1;
    tick();
    chk("midreset_release_ready", {31'd0, pushReady}, 32'd1);
    tick(); tick();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
